bpu_btb: RTL and testbench
==========================

# bpu_btb

Parametrised branch target buffer for the fetch stage, replacing the single-bit direct-mapped predictor. It adds partial tags, N-bit saturating direction counters, a valid-bit sweep state machine for reset and flush, and saturating performance counters. IF uses it for combinational next-PC prediction. The MEM stage writes resolved branch outcomes back into it.

## Interface
Parameters:
- PC_WIDTH, 32, address width.
- INDEX_WIDTH, 6, table index bits; depth = 2**INDEX_WIDTH.
- TAG_WIDTH, 8, stored partial-tag bits.
- CTR_WIDTH, 2, direction counter width (>=1).
- CNT_WIDTH, 32, statistics counter width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  request full invalidation of the table.
- ready  out  1  table usable; low during sweep.
- lookup_en  in  1  IF is issuing a real fetch; used for statistics only.
- current_pc  in  PC_WIDTH  fetch PC.
- predicted_pc  out  PC_WIDTH  next fetch PC.
- btb_hit  out  1  lookup matched a valid entry.
- predict_taken  out  1  hit and counter MSB set.
- upd_valid  in  1  resolved branch this cycle.
- upd_pc  in  PC_WIDTH  PC of the resolved branch.
- upd_taken  in  1  actual direction.
- upd_target  in  PC_WIDTH  actual taken target.
- upd_mispredict  in  1  MEM detected a wrong prediction.
- stat_lookups  out  CNT_WIDTH  count of lookups while ready.
- stat_mispredicts  out  CNT_WIDTH  count of mispredicts while ready.

## Operation
- Index is pc[INDEX_WIDTH+1:2]. Tag is the next TAG_WIDTH bits above the index.
- Each entry holds: valid, tag, target[PC_WIDTH-1:2], ctr[CTR_WIDTH-1:0].
- Lookup is combinational:
  - btb_hit = ready & valid & tag match.
  - predict_taken = btb_hit & ctr MSB.
  - predicted_pc = predict_taken ? {target,2'b00} : current_pc+4, with +4 wrapping modulo 2**PC_WIDTH.
- Update applies only when upd_valid & ready:
  - Tag hit at the indexed entry: taken increments ctr, saturating at all-ones, and rewrites target; not-taken decrements ctr, saturating at 0.
  - Miss and taken: allocate the entry, overwriting any occupant. Set valid=1, tag, target, ctr = 2**(CTR_WIDTH-1) (weakly taken).
  - Miss and not-taken: no change.
- The FSM has two states, SWEEP and RUN:
  - SWEEP clears valid[sweep_idx] each cycle and increments sweep_idx.
  - After clearing index 2**INDEX_WIDTH-1, the FSM enters RUN.
  - ready = (state==RUN).
  - flush in RUN goes to SWEEP with sweep_idx=0.
  - flush in SWEEP restarts the sweep at idx 0.
- Tag, target and ctr arrays are never reset and may map to RAM. Only the valid bits are swept.
- Statistics:
  - stat_lookups increments on lookup_en & ready.
  - stat_mispredicts increments on upd_valid & upd_mispredict & ready.
  - Both saturate at all-ones and are not cleared by flush.

## Timing
- Reset (reset_n low, asynchronous) gives:
  - state=SWEEP, sweep_idx=0, ready=0.
  - Both stat counters 0.
  - btb_hit=0, predict_taken=0, predicted_pc=current_pc+4.
- After reset_n rises, the sweep takes 2**INDEX_WIDTH edges; ready is high after the edge that clears the last index. With INDEX_WIDTH=6, ready rises 64 edges after release.
- Prediction has zero-cycle latency. An update becomes visible to lookups from the cycle after its edge.
- Lookup and update to the same index in the same cycle: the lookup sees pre-update contents.
- flush and upd_valid in the same cycle: the update is dropped and the sweep starts.
- reset_n asserted mid-sweep aborts the sweep; it restarts at 0 after release.
- Updates arriving during SWEEP are dropped silently; the MEM stage does not stall on ready.

## Structure
- Package bpu_pkg holds:
  - State enum SWEEP/RUN.
  - Helper functions bpu_index(pc) and bpu_tag(pc).
  - Counter constants CTR_MAX and CTR_WEAK_TAKEN.
- Sub-module bpu_sat_ctr is a parametrised saturating up/down counter. It serves both the entry counters (as a next-value function) and the statistics counters (registered).

## Test plan
(Defaults unless stated.)
- Release reset_n and hold current_pc=0x00400000: ready=0 for 64 edges, then 1; predicted_pc=0x00400004 and btb_hit=0 throughout.
- Update upd_pc=0x00400010, taken, target 0x00400100, then look up 0x00400010: next cycle btb_hit=1, predict_taken=1, predicted_pc=0x00400100.
- Counter behaviour on that entry:
  - Two not-taken updates: hit=1, predict_taken=0, predicted_pc=0x00400014.
  - Then five taken updates: ctr saturates at 3.
  - Then one not-taken: still predicts 0x00400100.
- Aliasing: look up 0x00400110 (same index 4, tag 0x01 vs 0x00): btb_hit=0. A taken update for it replaces the entry, and 0x00400010 then misses.
- Flush in RUN together with upd_valid: ready low for 64 cycles, the update is dropped, all prior entries miss. Assert reset_n at sweep cycle 30: the sweep restarts and ready rises 64 edges after release.
- Statistics with CNT_WIDTH=4: 20 lookup_en cycles give stat_lookups=15 (saturated). Mispredict pulses during SWEEP are not counted; flush leaves the counts intact.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch target buffer: FSM states,
// PC field extraction and direction-counter constants.
package bpu_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } bpu_state_e;

  function automatic logic [63:0] bpu_field_mask(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

  // Index sits just above the word offset; the partial tag sits above the index.
  function automatic logic [63:0] bpu_index(input logic [63:0] pc, input int index_width);
    return (pc >> 2) & bpu_field_mask(index_width);
  endfunction

  function automatic logic [63:0] bpu_tag(input logic [63:0] pc, input int index_width,
                                          input int tag_width);
    return (pc >> (index_width + 2)) & bpu_field_mask(tag_width);
  endfunction

  function automatic logic [63:0] bpu_ctr_max(input int width);
    return bpu_field_mask(width);
  endfunction

  function automatic logic [63:0] bpu_ctr_weak_taken(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/bpu_sat_ctr.sv
// Saturating up/down next-value function; callers own the register (if any).
module bpu_sat_ctr
  import bpu_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH-1:0] CTR_MAX = WIDTH'(bpu_ctr_max(WIDTH));

  always_comb begin
    nxt = cur;
    if (inc && !dec && (cur != CTR_MAX)) begin
      nxt = cur + WIDTH'(1);
    end else if (dec && !inc && (cur != '0)) begin
      nxt = cur - WIDTH'(1);
    end
  end

endmodule

// File: rtl/bpu_btb.sv
// Branch target buffer with partial tags, saturating direction counters,
// a valid-bit sweep FSM for reset/flush, and saturating statistics.
module bpu_btb
  import bpu_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 8,
  parameter int CTR_WIDTH   = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  output logic                ready,
  input  logic                lookup_en,
  input  logic [PC_WIDTH-1:0] current_pc,
  output logic [PC_WIDTH-1:0] predicted_pc,
  output logic                btb_hit,
  output logic                predict_taken,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [PC_WIDTH-1:0] upd_target,
  input  logic                upd_mispredict,
  output logic [CNT_WIDTH-1:0] stat_lookups,
  output logic [CNT_WIDTH-1:0] stat_mispredicts,
  output bpu_state_e          dbg_state
);

  localparam int DEPTH = 2 ** INDEX_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_WEAK_TAKEN = CTR_WIDTH'(bpu_ctr_weak_taken(CTR_WIDTH));

  bpu_state_e             state;
  logic [INDEX_WIDTH-1:0] sweep_idx;

  logic                   valid_q [DEPTH];
  logic [TAG_WIDTH-1:0]   tag_mem [DEPTH];
  logic [PC_WIDTH-3:0]    tgt_mem [DEPTH];
  logic [CTR_WIDTH-1:0]   ctr_mem [DEPTH];

  logic [INDEX_WIDTH-1:0] lk_idx, up_idx;
  logic [TAG_WIDTH-1:0]   lk_tag, up_tag;
  logic                   up_hit, up_en;
  logic [CTR_WIDTH-1:0]   ctr_nxt;
  logic [CNT_WIDTH-1:0]   lookups_nxt, mispredicts_nxt;

  assign ready     = (state == RUN);
  assign dbg_state = state;

  assign lk_idx = INDEX_WIDTH'(bpu_index(64'(current_pc), INDEX_WIDTH));
  assign lk_tag = TAG_WIDTH'(bpu_tag(64'(current_pc), INDEX_WIDTH, TAG_WIDTH));
  assign up_idx = INDEX_WIDTH'(bpu_index(64'(upd_pc), INDEX_WIDTH));
  assign up_tag = TAG_WIDTH'(bpu_tag(64'(upd_pc), INDEX_WIDTH, TAG_WIDTH));

  // Lookup reads array contents combinationally, so same-cycle updates are not seen.
  assign btb_hit       = ready & valid_q[lk_idx] & (tag_mem[lk_idx] == lk_tag);
  assign predict_taken = btb_hit & ctr_mem[lk_idx][CTR_WIDTH-1];
  assign predicted_pc  = predict_taken ? {tgt_mem[lk_idx], 2'b00} : current_pc + PC_WIDTH'(4);

  // upd_valid is a one-cycle pulse with no backpressure: it takes effect only
  // when ready is high and no flush is requested; otherwise it is discarded.
  assign up_hit = valid_q[up_idx] & (tag_mem[up_idx] == up_tag);
  assign up_en  = upd_valid & ready & ~flush;

  bpu_sat_ctr #(.WIDTH(CTR_WIDTH)) u_entry_ctr (
    .cur (ctr_mem[up_idx]),
    .inc (upd_taken),
    .dec (~upd_taken),
    .nxt (ctr_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SWEEP;
      sweep_idx <= '0;
    end else if (flush) begin
      state     <= SWEEP;
      sweep_idx <= '0;
    end else if (state == SWEEP) begin
      sweep_idx <= sweep_idx + INDEX_WIDTH'(1);
      if (sweep_idx == '1) state <= RUN;
    end
  end

  // Valid bits are initialised by the sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (state == SWEEP) begin
      valid_q[sweep_idx] <= 1'b0;
    end else if (up_en && !up_hit && upd_taken) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (up_en) begin
      if (up_hit) begin
        ctr_mem[up_idx] <= ctr_nxt;
        if (upd_taken) tgt_mem[up_idx] <= (PC_WIDTH-2)'(upd_target >> 2);
      end else if (upd_taken) begin
        tag_mem[up_idx] <= up_tag;
        tgt_mem[up_idx] <= (PC_WIDTH-2)'(upd_target >> 2);
        ctr_mem[up_idx] <= CTR_WEAK_TAKEN;
      end
    end
  end

  bpu_sat_ctr #(.WIDTH(CNT_WIDTH)) u_stat_lookups (
    .cur (stat_lookups),
    .inc (lookup_en & ready),
    .dec (1'b0),
    .nxt (lookups_nxt)
  );

  bpu_sat_ctr #(.WIDTH(CNT_WIDTH)) u_stat_mispredicts (
    .cur (stat_mispredicts),
    .inc (upd_valid & upd_mispredict & ready),
    .dec (1'b0),
    .nxt (mispredicts_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      stat_lookups     <= lookups_nxt;
      stat_mispredicts <= mispredicts_nxt;
    end
  end

endmodule

// File: tb/tb_bpu_btb.sv
// Directed bench for bpu_btb: sweep timing, counters, aliasing, flush,
// reset mid-sweep and saturating statistics.
module tb_bpu_btb;
  import bpu_pkg::*;

  localparam int PC_WIDTH  = 32;
  localparam int CNT_WIDTH = 4;

  logic                 clk;
  logic                 reset_n;
  logic                 flush;
  logic                 ready;
  logic                 lookup_en;
  logic [PC_WIDTH-1:0]  current_pc;
  logic [PC_WIDTH-1:0]  predicted_pc;
  logic                 btb_hit;
  logic                 predict_taken;
  logic                 upd_valid;
  logic [PC_WIDTH-1:0]  upd_pc;
  logic                 upd_taken;
  logic [PC_WIDTH-1:0]  upd_target;
  logic                 upd_mispredict;
  logic [CNT_WIDTH-1:0] stat_lookups;
  logic [CNT_WIDTH-1:0] stat_mispredicts;
  bpu_state_e           dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  bpu_btb #(
    .PC_WIDTH    (PC_WIDTH),
    .INDEX_WIDTH (6),
    .TAG_WIDTH   (8),
    .CTR_WIDTH   (2),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .flush            (flush),
    .ready            (ready),
    .lookup_en        (lookup_en),
    .current_pc       (current_pc),
    .predicted_pc     (predicted_pc),
    .btb_hit          (btb_hit),
    .predict_taken    (predict_taken),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .stat_lookups     (stat_lookups),
    .stat_mispredicts (stat_mispredicts),
    .dbg_state        (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    current_pc = pc;
    #1;
  endtask

  task automatic expect_pred(input string tag, input logic hit, input logic tk,
                             input logic [31:0] pc);
    chk({tag, "_hit"}, 32'(btb_hit), 32'(hit));
    chk({tag, "_taken"}, 32'(predict_taken), 32'(tk));
    chk({tag, "_pc"}, predicted_pc, pc);
  endtask

  task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic mis);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_mispredict = mis;
    tick();
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic sweep_wait(input string tag);
    for (int i = 1; i <= 64; i++) begin
      tick();
      chk(tag, 32'(ready), 32'(i == 64));
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    flush          = 1'b0;
    lookup_en      = 1'b0;
    current_pc     = 32'h0040_0000;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_taken      = 1'b0;
    upd_target     = '0;
    upd_mispredict = 1'b0;
    #2;

    // Reset state
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(SWEEP));
    chk("rst_stat_lk", 32'(stat_lookups), 32'd0);
    chk("rst_stat_mp", 32'(stat_mispredicts), 32'd0);
    expect_pred("rst", 1'b0, 1'b0, 32'h0040_0004);
    tick();
    tick();
    reset_n = 1'b1;

    // Initial sweep: ready after exactly 64 edges, no hits meanwhile
    for (int i = 1; i <= 64; i++) begin
      tick();
      chk("init_sweep_ready", 32'(ready), 32'(i == 64));
      chk("init_sweep_hit", 32'(btb_hit), 32'd0);
      chk("init_sweep_pc", predicted_pc, 32'h0040_0004);
    end
    chk("run_state", 32'(dbg_state), 32'(RUN));

    // Allocation; same-cycle lookup sees the old contents
    current_pc     = 32'h0040_0010;
    upd_valid      = 1'b1;
    upd_pc         = 32'h0040_0010;
    upd_taken      = 1'b1;
    upd_target     = 32'h0040_0100;
    #1;
    chk("same_cycle_hit", 32'(btb_hit), 32'd0);
    tick();
    upd_valid = 1'b0;
    #1;
    expect_pred("alloc", 1'b1, 1'b1, 32'h0040_0100);

    // Two not-taken (flagged mispredicts): ctr 2 -> 1 -> 0
    update(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1);
    look(32'h0040_0010);
    expect_pred("nt1", 1'b1, 1'b0, 32'h0040_0014);
    update(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1);
    look(32'h0040_0010);
    expect_pred("nt2", 1'b1, 1'b0, 32'h0040_0014);
    chk("stat_mp_run", 32'(stat_mispredicts), 32'd2);

    // Five taken: ctr 1,2,3,3,3
    update(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
    look(32'h0040_0010);
    expect_pred("tk1", 1'b1, 1'b0, 32'h0040_0014);
    for (int i = 2; i <= 5; i++) begin
      update(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
      look(32'h0040_0010);
      expect_pred("tk_n", 1'b1, 1'b1, 32'h0040_0100);
    end
    // Saturated at 3, so one not-taken leaves it weakly taken
    update(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b0);
    look(32'h0040_0010);
    expect_pred("sat_nt", 1'b1, 1'b1, 32'h0040_0100);

    // Aliasing: same index 4, tag 0x01 vs 0x00
    look(32'h0040_0110);
    expect_pred("alias_miss", 1'b0, 1'b0, 32'h0040_0114);
    update(32'h0040_0110, 1'b1, 32'h0040_0200, 1'b0);
    look(32'h0040_0110);
    expect_pred("alias_new", 1'b1, 1'b1, 32'h0040_0200);
    look(32'h0040_0010);
    expect_pred("alias_old", 1'b0, 1'b0, 32'h0040_0014);

    // Not-taken miss allocates nothing, then a taken allocation at index 8
    update(32'h0040_0020, 1'b0, 32'h0040_0300, 1'b0);
    look(32'h0040_0020);
    expect_pred("nt_miss", 1'b0, 1'b0, 32'h0040_0024);
    update(32'h0040_0020, 1'b1, 32'h0040_0300, 1'b0);
    look(32'h0040_0020);
    expect_pred("idx8", 1'b1, 1'b1, 32'h0040_0300);

    // Fall-through wraps at the top of the address space
    look(32'hFFFF_FFFC);
    expect_pred("wrap", 1'b0, 1'b0, 32'h0000_0000);

    // Flush with a simultaneous update: update dropped, sweep starts
    flush          = 1'b1;
    upd_valid      = 1'b1;
    upd_pc         = 32'h0040_0040;
    upd_taken      = 1'b1;
    upd_target     = 32'h0040_0400;
    tick();
    flush     = 1'b0;
    upd_valid = 1'b0;
    chk("flush_ready", 32'(ready), 32'd0);
    // Mispredict pulses and lookups during the sweep are not counted
    upd_valid      = 1'b1;
    upd_mispredict = 1'b1;
    upd_taken      = 1'b0;
    lookup_en      = 1'b1;
    sweep_wait("flush_sweep_ready");
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
    lookup_en      = 1'b0;
    chk("flush_stat_mp", 32'(stat_mispredicts), 32'd2);
    chk("flush_stat_lk", 32'(stat_lookups), 32'd0);
    look(32'h0040_0110);
    expect_pred("flushed_a", 1'b0, 1'b0, 32'h0040_0114);
    look(32'h0040_0020);
    expect_pred("flushed_b", 1'b0, 1'b0, 32'h0040_0024);
    look(32'h0040_0040);
    expect_pred("dropped_upd", 1'b0, 1'b0, 32'h0040_0044);

    // Reset asserted at sweep cycle 30 aborts the sweep
    update(32'h0040_0040, 1'b1, 32'h0040_0400, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (30) tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(SWEEP));
    chk("midrst_stat_mp", 32'(stat_mispredicts), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    sweep_wait("midrst_sweep_ready");
    look(32'h0040_0040);
    expect_pred("after_midrst", 1'b0, 1'b0, 32'h0040_0044);

    // Lookup statistic saturates at 15 with a 4-bit counter
    lookup_en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("stat_lk", 32'(stat_lookups), 32'((i > 15) ? 15 : i));
    end
    lookup_en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      update(32'h0040_0080, 1'b0, 32'h0, 1'b1);
      chk("stat_mp", 32'(stat_mispredicts), 32'(i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
